alm_div_32by16_signed: RTL and testbench

Multicycle approximate signed divider using Mitchell log-domain arithmetic with dynamic-range (DR) truncation. It inverts the 16×16 DR-ALM multiplier: a 32-bit signed product divided by one 16-bit signed operand recovers the other operand approximately, as a saturated 16-bit signed quotient. It sits beside the multiplier in the approximate-arithmetic datapath. Operands enter and results leave through valid/ready handshakes, with one operation in flight at a time.

---
 rtl/alm_div_32by16_signed_if.sv | 22 ++
 rtl/alm_div_32by16_signed.sv | 137 +++++++++++++
 tb/tb_alm_div_32by16_signed.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alm_div_32by16_signed_if.sv
// Operand/result handshake bundle for the approximate 32/16 signed divider.
// slave faces the divider, master faces whoever feeds and drains it.
interface alm_div_32by16_signed_if;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_a;
  logic [15:0] i_b;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] o_q;
  logic        o_dz;

  modport slave (
    input  i_valid, i_a, i_b, i_ready,
    output o_ready, o_valid, o_q, o_dz
  );

  modport master (
    output i_valid, i_a, i_b, i_ready,
    input  o_ready, o_valid, o_q, o_dz
  );
endinterface

// File: rtl/alm_div_32by16_signed.sv
// Approximate signed 32/16 divider: Mitchell log-domain with DR truncation.
// Five-state multicycle FSM, one operation in flight.
module alm_div_32by16_signed #(
  parameter int TRUNC_WIDTH = 6
) (
  input logic i_clk,
  input logic i_rst_n,
  alm_div_32by16_signed_if.slave bus
);
  localparam int T  = TRUNC_WIDTH;
  localparam int F  = T + 1;
  localparam int KW = 7;
  localparam int LW = F + KW;
  localparam int MW = F + 33;

  typedef enum logic [2:0] {
    IDLE, LOG, SUB, EXP, OUT
  } state_t;

  state_t state, state_n;

  logic [31:0]   a_r;
  logic [15:0]   b_r;
  logic          s_r, an_r, za_r, zb_r;
  logic [4:0]    ka_r;
  logic [3:0]    kb_r;
  logic [F-1:0]  fa_r, fb_r, f_r;
  logic [KW-1:0] k_r;
  logic [15:0]   q_r;
  logic          dz_r;

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else          state <= state_n;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (bus.i_valid) state_n = LOG;
      LOG:     state_n = SUB;
      SUB:     state_n = EXP;
      EXP:     state_n = OUT;
      OUT:     if (bus.i_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  logic [31:0]  aa;
  logic [15:0]  ba;
  logic [4:0]   ka;
  logic [3:0]   kb;
  logic [T-1:0] xa, xb;

  // Normalise so the leading one sits at the MSB, then take the bits below it.
  always_comb begin
    aa = a_r[31] ? ~a_r + 32'd1 : a_r;
    ba = b_r[15] ? ~b_r + 16'd1 : b_r;
    ka = '0;
    kb = '0;
    for (int i = 0; i < 32; i++)
      if (aa[i]) ka = 5'(i);
    for (int i = 0; i < 16; i++)
      if (ba[i]) kb = 4'(i);
    xa = T'((aa << (5'd31 - ka)) >> (31 - T));
    xb = T'((ba << (4'd15 - kb)) >> (15 - T));
  end

  logic [LW-1:0] la, lb, l;

  assign la = LW'({ka_r, fa_r});
  assign lb = LW'({kb_r, fb_r});
  assign l  = la - lb;

  logic [32:0] qm;
  logic [15:0] q_n;

  // Shift amount k never exceeds 31, so a 33-bit magnitude cannot wrap.
  always_comb begin
    qm = k_r[KW-1] ? 33'd0
                   : 33'((MW'({1'b1, f_r}) << k_r) >> F);
    if (zb_r)
      q_n = an_r ? 16'h8000 : 16'h7fff;
    else if (za_r)
      q_n = '0;
    else if (!s_r)
      q_n = (qm > 33'd32767) ? 16'h7fff : qm[15:0];
    else
      q_n = (qm > 33'd32768) ? 16'h8000 : ~qm[15:0] + 16'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_r  <= '0;
      b_r  <= '0;
      s_r  <= 1'b0;
      an_r <= 1'b0;
      za_r <= 1'b0;
      zb_r <= 1'b0;
      ka_r <= '0;
      kb_r <= '0;
      fa_r <= '0;
      fb_r <= '0;
      k_r  <= '0;
      f_r  <= '0;
      q_r  <= '0;
      dz_r <= 1'b0;
    end else begin
      if (state == IDLE && bus.i_valid) begin
        a_r <= bus.i_a;
        b_r <= bus.i_b;
      end
      if (state == LOG) begin
        s_r  <= a_r[31] ^ b_r[15];
        an_r <= a_r[31];
        za_r <= (a_r == '0);
        zb_r <= (b_r == '0);
        ka_r <= ka;
        kb_r <= kb;
        fa_r <= {xa, 1'b1};
        fb_r <= {xb, 1'b1};
      end
      if (state == SUB) begin
        k_r <= l[LW-1:F];
        f_r <= l[F-1:0];
      end
      if (state == EXP) begin
        q_r  <= q_n;
        dz_r <= zb_r;
      end
    end
  end

  assign bus.o_ready = (state == IDLE);
  assign bus.o_valid = (state == OUT);
  assign bus.o_q     = q_r;
  assign bus.o_dz    = dz_r;
endmodule

// File: tb/tb_alm_div_32by16_signed.sv
// Bench for alm_div_32by16_signed: directed vectors plus a log-domain model
// checked on every valid output cycle for TRUNC_WIDTH 4, 6 and 8.
module tb_alm_div_32by16_signed;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   nchk = 0;
  int   npass = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  alm_div_32by16_signed_if bi4 ();
  alm_div_32by16_signed_if bi6 ();
  alm_div_32by16_signed_if bi8 ();

  assign bi4.i_valid = bi6.i_valid;
  assign bi4.i_a     = bi6.i_a;
  assign bi4.i_b     = bi6.i_b;
  assign bi4.i_ready = bi6.i_ready;
  assign bi8.i_valid = bi6.i_valid;
  assign bi8.i_a     = bi6.i_a;
  assign bi8.i_b     = bi6.i_b;
  assign bi8.i_ready = bi6.i_ready;

  alm_div_32by16_signed #(.TRUNC_WIDTH(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bi4));
  alm_div_32by16_signed #(.TRUNC_WIDTH(6)) dut6 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bi6));
  alm_div_32by16_signed #(.TRUNC_WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bi8));

  function automatic void chk(string nm, longint act, longint exp);
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endfunction

  // Reference from the arithmetic definition: log2 split, floor, antilog.
  function automatic longint model(int t, logic [31:0] a,
                                   logic [15:0] b, output bit dz);
    longint aa, bb, fa, fb, lg, k, f, q, one, sc;
    int ka, kb;
    one = 1;
    sc  = one << (t + 1);
    dz  = 1'b0;
    aa  = longint'($signed(a));
    bb  = longint'($signed(b));
    if (aa < 0) aa = -aa;
    if (bb < 0) bb = -bb;
    if (bb == 0) begin
      dz = 1'b1;
      return a[31] ? -32768 : 32767;
    end
    if (aa == 0) return 0;
    ka = 0;
    while ((one << (ka + 1)) <= aa) ka++;
    kb = 0;
    while ((one << (kb + 1)) <= bb) kb++;
    fa = 2 * (((aa - (one << ka)) << t) >> ka) + 1;
    fb = 2 * (((bb - (one << kb)) << t) >> kb) + 1;
    lg = ka * sc + fa - kb * sc - fb;
    if (lg >= 0) k = lg / sc;
    else k = -((-lg + sc - 1) / sc);
    f = lg - k * sc;
    if (k < 0) q = 0;
    else q = ((sc + f) << k) / sc;
    if (a[31] == b[15]) return (q > 32767) ? 32767 : q;
    return (q > 32768) ? -32768 : -q;
  endfunction

  typedef struct {
    logic [31:0] a;
    logic [15:0] b;
    int          t0;
  } op_t;

  op_t opq[$];
  bit  seen = 1'b0;

  always @(negedge clk) begin : cmp
    bit d;
    longint e;
    cyc++;
    if (!rst_n) begin
      opq.delete();
      seen = 1'b0;
    end else begin
      if (bi6.o_valid) begin
        if (opq.size() == 0) begin
          chk("orphan_valid", longint'(opq.size()), 1);
        end else begin
          if (!seen) chk("latency", longint'(cyc - opq[0].t0), 4);
          seen = 1'b1;
          e = model(4, opq[0].a, opq[0].b, d);
          chk("q_t4", longint'($signed(bi4.o_q)), e);
          chk("dz_t4", longint'(bi4.o_dz), longint'(d));
          e = model(6, opq[0].a, opq[0].b, d);
          chk("q_t6", longint'($signed(bi6.o_q)), e);
          chk("dz_t6", longint'(bi6.o_dz), longint'(d));
          e = model(8, opq[0].a, opq[0].b, d);
          chk("q_t8", longint'($signed(bi8.o_q)), e);
          chk("dz_t8", longint'(bi8.o_dz), longint'(d));
          chk("ready_in_out", longint'(bi6.o_ready), 0);
          if (bi6.i_ready) begin
            void'(opq.pop_front());
            seen = 1'b0;
          end
        end
      end
      if (bi6.i_valid && bi6.o_ready)
        opq.push_back('{bi6.i_a, bi6.i_b, cyc});
    end
  end

  task automatic op(input logic [31:0] a, input logic [15:0] b,
                    input longint eq, input bit edz,
                    input int hold, input string nm);
    int n;
    bi6.i_a     = a;
    bi6.i_b     = b;
    bi6.i_valid = 1'b1;
    bi6.i_ready = (hold == 0);
    n = 0;
    @(negedge clk);
    while (!bi6.o_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bi6.o_ready) begin
      chk({nm, "_accept_timeout"}, longint'(bi6.o_ready), 1);
      bi6.i_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 bi6.i_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bi6.o_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_valid"}, longint'(bi6.o_valid), 1);
    chk({nm, "_q"}, longint'($signed(bi6.o_q)), eq);
    chk({nm, "_dz"}, longint'(bi6.o_dz), longint'(edz));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      bi6.i_valid = 1'($urandom_range(0, 1));
      bi6.i_a     = $urandom;
      bi6.i_b     = 16'($urandom);
      @(negedge clk);
      chk({nm, "_hold_q"}, longint'($signed(bi6.o_q)), eq);
      chk({nm, "_hold_ready"}, longint'(bi6.o_ready), 0);
      chk({nm, "_hold_valid"}, longint'(bi6.o_valid), 1);
    end
    if (hold > 0) begin
      @(posedge clk);
      #1;
      bi6.i_valid = 1'b0;
      bi6.i_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk({nm, "_rel_ready"}, longint'(bi6.o_ready), 1);
      chk({nm, "_rel_valid"}, longint'(bi6.o_valid), 0);
      chk({nm, "_rel_q"}, longint'($signed(bi6.o_q)), eq);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_a();
    logic [31:0] v;
    v = $urandom >> $urandom_range(0, 31);
    if ($urandom_range(0, 15) == 0) v = 32'h8000_0000;
    if ($urandom_range(0, 15) == 0) v = '0;
    if ($urandom_range(0, 1) == 1) v = ~v + 32'd1;
    return v;
  endfunction

  function automatic logic [15:0] rnd_b();
    logic [15:0] v;
    v = 16'($urandom) >> $urandom_range(0, 15);
    if ($urandom_range(0, 7) == 0) v = '0;
    return v;
  endfunction

  initial begin : wd
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    bit d;
    bit vseen;
    bi6.i_valid = 1'b0;
    bi6.i_ready = 1'b1;
    bi6.i_a     = '0;
    bi6.i_b     = '0;

    chk("model_300_10", model(6, 32'd300, 16'd10, d), 30);
    chk("model_5_100", model(6, 32'd5, 16'd100, d), 0);
    chk("model_4096_64", model(6, 32'd4096, 16'd64, d), 64);
    chk("model_t4_300_10", model(4, 32'd300, 16'd10, d), 30);
    chk("model_min_m1", model(6, 32'h8000_0000, 16'hffff, d), 32767);
    void'(model(6, 32'd9, 16'd0, d));
    chk("model_dz", longint'(d), 1);

    #1 rst_n = 1'b0;
    #1;
    chk("rst_ready", longint'(bi6.o_ready), 1);
    chk("rst_valid", longint'(bi6.o_valid), 0);
    chk("rst_q", longint'(bi6.o_q), 0);
    chk("rst_dz", longint'(bi6.o_dz), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    op(32'd4096, 16'd64, 64, 0, 0, "p4096_64");
    op(32'hffff_f000, 16'd64, -64, 0, 0, "n4096_64");
    op(32'd300, 16'd10, 30, 0, 0, "d300_10");
    op(32'd5, 16'd100, 0, 0, 0, "d5_100");
    op(32'd5, 16'd0, 32767, 1, 0, "dz_pos");
    op(32'hffff_fff9, 16'd0, -32768, 1, 0, "dz_neg");
    op(32'd0, 16'd3, 0, 0, 0, "zero_a");
    op(32'h4000_0000, 16'd1, 32767, 0, 0, "sat_pos");
    op(32'h8000_0000, 16'd1, -32768, 0, 0, "sat_neg");
    op(32'h8000_0000, 16'hffff, 32767, 0, 0, "sat_minm1");
    op(32'd300, 16'd10, 30, 0, 10, "bp");

    op(32'd300, 16'd10, 30, 0, 0, "pre_rst");
    bi6.i_a     = 32'd5;
    bi6.i_b     = 16'd100;
    bi6.i_valid = 1'b1;
    @(posedge clk);
    #1 bi6.i_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_valid", longint'(bi6.o_valid), 0);
    chk("midrst_q", longint'(bi6.o_q), 0);
    chk("midrst_ready", longint'(bi6.o_ready), 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    vseen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bi6.o_valid) vseen = 1'b1;
    end
    chk("midrst_no_valid", longint'(vseen), 0);
    @(posedge clk);
    #1;
    op(32'd300, 16'd10, 30, 0, 0, "post_rst");

    for (int c = 0; c < 400; c++) begin
      bi6.i_valid = ($urandom_range(0, 3) != 0);
      bi6.i_a     = rnd_a();
      bi6.i_b     = rnd_b();
      bi6.i_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    bi6.i_valid = 1'b0;
    bi6.i_ready = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("drain", longint'(opq.size()), 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
